// File: rtl/aer_spike_out_encoder.sv
// Serialises per-lane spike vectors and time-step markers into a buffered 4-phase AER stream.
// Optional saturating spike-word counter is built when AER_SPIKE_CNT_EN is defined.
module aer_spike_out_encoder #(
    parameter int POST_NEUR_PARALLEL   = 4,
    parameter int POST_NEUR_ADDR_WIDTH = 10,
    parameter int AER_WIDTH            = 12,
    parameter int FIFO_DEPTH           = 16,
    parameter int TIME_STEP            = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            evt_valid_i,
    input  logic [POST_NEUR_PARALLEL-1:0]   evt_spikes_i,
    input  logic [POST_NEUR_ADDR_WIDTH-1:0] evt_base_addr_i,
    input  logic                            ctrl_tstep_event_i,
    input  logic                            ctrl_tref_event_i,
    output logic                            evt_stall_o,
    output logic [AER_WIDTH-1:0]            aer_addr_o,
    output logic                            aer_req_o,
    input  logic                            aer_ack_i,
    output logic                            fifo_empty_o,
    output logic                            err_drop_o,
    output logic [15:0]                     spike_evt_cnt_o
);

    localparam int LANE_W = (POST_NEUR_PARALLEL > 1) ? $clog2(POST_NEUR_PARALLEL) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int STEP_W = (TIME_STEP > 1) ? $clog2(TIME_STEP) : 1;

    localparam logic [1:0] TYPE_SPIKE = 2'b00;
    localparam logic [1:0] TYPE_MARK  = 2'b01;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_REL  = 2'b10;

    localparam logic [PTR_W:0]    LEVEL_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(TIME_STEP - 1);

    function automatic logic [LANE_W-1:0] lowest_lane(input logic [POST_NEUR_PARALLEL-1:0] m);
        lowest_lane = '0;
        for (int i = POST_NEUR_PARALLEL - 1; i >= 0; i--) begin
            if (m[i]) lowest_lane = LANE_W'(i);
        end
    endfunction

    function automatic logic [AER_WIDTH-1:0] make_word(input logic [1:0] typ,
                                                       input logic [POST_NEUR_ADDR_WIDTH-1:0] payload);
        make_word = '0;
        make_word[AER_WIDTH-1 -: 2]         = typ;
        make_word[POST_NEUR_ADDR_WIDTH-1:0] = payload;
    endfunction

    logic [POST_NEUR_PARALLEL-1:0]   mask_q, mask_d;
    logic [POST_NEUR_ADDR_WIDTH-1:0] base_q;
    logic                            tpend_q, tpend_d;
    logic [STEP_W-1:0]               step_q, step_d;
    logic                            err_q;
    logic [AER_WIDTH-1:0]            mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]                wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]                  level_q, level_d;
    logic [1:0]                      state_q, state_d;
    logic [AER_WIDTH-1:0]            aer_addr_q, aer_addr_d;

    logic                 capture, drop, fifo_full, push, push_mark, pop;
    logic [AER_WIDTH-1:0] push_word;

    assign evt_stall_o  = |mask_q;
    assign fifo_full    = (level_q == LEVEL_FULL);
    assign fifo_empty_o = (level_q == '0);
    assign capture      = evt_valid_i && !evt_stall_o && (evt_spikes_i != '0);
    assign drop         = evt_valid_i && evt_stall_o;
    assign aer_req_o    = (state_q == ST_REQ);
    assign aer_addr_o   = aer_addr_q;
    assign err_drop_o   = err_q;

    // Spikes drain first; a marker only goes out once the captured vector is empty.
    always_comb begin
        push      = 1'b0;
        push_mark = 1'b0;
        push_word = '0;
        mask_d    = mask_q;
        if (|mask_q) begin
            if (!fifo_full) begin
                push      = 1'b1;
                push_word = make_word(TYPE_SPIKE,
                                      base_q | POST_NEUR_ADDR_WIDTH'(lowest_lane(mask_q)));
                mask_d    = mask_q & (mask_q - POST_NEUR_PARALLEL'(1));
            end
        end else begin
            if (tpend_q && !fifo_full) begin
                push      = 1'b1;
                push_mark = 1'b1;
                push_word = make_word(TYPE_MARK, POST_NEUR_ADDR_WIDTH'(step_q));
            end
            if (capture) mask_d = evt_spikes_i;
        end
    end

    always_comb begin
        tpend_d = push_mark ? 1'b0 : (tpend_q | ctrl_tstep_event_i);
        step_d  = step_q;
        if (push_mark) step_d = (step_q == STEP_LAST) ? '0 : step_q + STEP_W'(1);
        if (ctrl_tref_event_i) step_d = '0;
    end

    always_comb begin
        pop        = 1'b0;
        state_d    = state_q;
        aer_addr_d = aer_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_o) begin
                    pop        = 1'b1;
                    aer_addr_d = mem_q[rd_ptr_q];
                    state_d    = ST_REQ;
                end
            end
            ST_REQ:  if (aer_ack_i)  state_d = ST_REL;
            ST_REL:  if (!aer_ack_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case ({push, pop})
            2'b10:   level_d = level_q + (PTR_W + 1)'(1);
            2'b01:   level_d = level_q - (PTR_W + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mask_q     <= '0;
            tpend_q    <= 1'b0;
            step_q     <= '0;
            err_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            state_q    <= ST_IDLE;
            aer_addr_q <= '0;
        end else begin
            mask_q     <= mask_d;
            tpend_q    <= tpend_d;
            step_q     <= step_d;
            err_q      <= err_q | drop;
            level_q    <= level_d;
            state_q    <= state_d;
            aer_addr_q <= aer_addr_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Storage only; validity is tracked by the pointers and mask above.
    always_ff @(posedge clk_i) begin
        if (capture) base_q <= evt_base_addr_i;
        if (push)    mem_q[wr_ptr_q] <= push_word;
    end

`ifdef AER_SPIKE_CNT_EN
    logic [15:0] scnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scnt_q <= '0;
        end else if (ctrl_tref_event_i) begin
            scnt_q <= '0;
        end else if (state_q == ST_REQ && aer_ack_i &&
                     aer_addr_q[AER_WIDTH-1 -: 2] == TYPE_SPIKE && scnt_q != 16'hFFFF) begin
            scnt_q <= scnt_q + 16'd1;
        end
    end

    assign spike_evt_cnt_o = scnt_q;
`else
    assign spike_evt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_aer_spike_out_encoder.sv
// Bench for aer_spike_out_encoder: directed table and corner sequences plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_aer_spike_out_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        evt_valid = 1'b0;
    logic [3:0]  evt_spikes = '0;
    logic [9:0]  evt_base = '0;
    logic        tstep = 1'b0;
    logic        tref = 1'b0;
    logic        ack = 1'b0;
    logic        evt_stall, aer_req, fifo_empty, err_drop;
    logic [11:0] aer_addr;
    logic [15:0] spike_cnt;

`ifdef AER_SPIKE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    aer_spike_out_encoder dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .evt_valid_i        (evt_valid),
        .evt_spikes_i       (evt_spikes),
        .evt_base_addr_i    (evt_base),
        .ctrl_tstep_event_i (tstep),
        .ctrl_tref_event_i  (tref),
        .evt_stall_o        (evt_stall),
        .aer_addr_o         (aer_addr),
        .aer_req_o          (aer_req),
        .aer_ack_i          (ack),
        .fifo_empty_o       (fifo_empty),
        .err_drop_o         (err_drop),
        .spike_evt_cnt_o    (spike_cnt)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model: pending lane addresses, FIFO contents and handshake phase as queues/ints.
    logic [11:0] m_lanes[$];
    logic [11:0] m_fifo[$];
    int          m_phase = 0;
    logic [11:0] m_out = '0;
    bit          m_tpend = 0;
    int          m_step = 0;
    bit          m_err = 0;
    int          m_cnt = 0;
    bit          m_had, m_dopush, m_mk;
    int          m_nold;
    logic [11:0] m_pw;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lanes.delete(); m_fifo.delete();
            m_phase = 0; m_out = '0; m_tpend = 0; m_step = 0; m_err = 0; m_cnt = 0;
        end else begin
            m_had = (m_lanes.size() != 0);
            m_nold = m_fifo.size();
            m_dopush = 0; m_mk = 0; m_pw = '0;
            if (m_had && m_nold < 16) begin
                m_pw = m_lanes.pop_front(); m_dopush = 1;
            end else if (!m_had && m_tpend && m_nold < 16) begin
                m_pw = {2'b01, 10'(m_step)}; m_dopush = 1; m_mk = 1;
                m_step = (m_step + 1) % 8;
            end
            case (m_phase)
                0: if (m_nold > 0) begin m_out = m_fifo.pop_front(); m_phase = 1; end
                1: if (ack) begin
                       m_phase = 2;
                       if (CNT_EN && m_out[11:10] == 2'b00 && m_cnt < 65535) m_cnt++;
                   end
                default: if (!ack) m_phase = 0;
            endcase
            if (m_dopush) m_fifo.push_back(m_pw);
            if (evt_valid) begin
                if (m_had) m_err = 1;
                else for (int i = 0; i < 4; i++) if (evt_spikes[i]) m_lanes.push_back({2'b00, evt_base | 10'(i)});
            end
            m_tpend = m_mk ? 0 : (m_tpend | tstep);
            if (tref) begin m_step = 0; m_cnt = 0; end
        end
    end

    // Per-cycle model comparison, word collection and ACK generation (0 hold, 1 echo, 2 random).
    int          ack_mode = 1;
    logic [11:0] got[$];

    always @(negedge clk) begin
        chk("m_stall", evt_stall, m_lanes.size() != 0);
        chk("m_empty", fifo_empty, m_fifo.size() == 0);
        chk("m_req", aer_req, m_phase == 1);
        chk("m_addr", aer_addr, m_out);
        chk("m_err", err_drop, m_err);
        chk("m_cnt", spike_cnt, m_cnt);
        if (aer_req && !ack && ack_mode != 0 && (ack_mode == 1 || $urandom_range(1, 0) == 1)) begin
            got.push_back(aer_addr);
            ack = 1'b1;
        end else if (!aer_req && ack && (ack_mode != 2 || $urandom_range(1, 0) == 1)) begin
            ack = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk); @(negedge clk); #1;
    endtask

    task automatic pulse_vec(input logic [9:0] base, input logic [3:0] spk, input logic ts);
        evt_base = base; evt_spikes = spk; evt_valid = 1'b1; tstep = ts;
        tick();
        evt_valid = 1'b0; tstep = 1'b0;
    endtask

    task automatic pulse_tstep();
        tstep = 1'b1; tick(); tstep = 1'b0;
    endtask

    task automatic pulse_tref();
        tref = 1'b1; tick(); tref = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        repeat (3) tick();
        while (!(!evt_stall && fifo_empty && !aer_req && !ack) && n < budget) begin
            tick(); n++;
        end
        chk({name, "_done"}, 32'(n < budget), 1);
    endtask

    typedef struct {
        logic [9:0]  base;
        logic [3:0]  spikes;
        logic        ts;
        int          n;
        logic [11:0] w[5];
    } vec_t;

    vec_t tbl[6];

    initial begin
        int lat;
        tbl[0] = '{10'h010, 4'b1010, 1'b0, 2, '{12'h011, 12'h013, 12'h0, 12'h0, 12'h0}};
        tbl[1] = '{10'h0F0, 4'b1111, 1'b1, 5, '{12'h0F0, 12'h0F1, 12'h0F2, 12'h0F3, 12'h400}};
        tbl[2] = '{10'h3FC, 4'b0001, 1'b0, 1, '{12'h3FC, 12'h0, 12'h0, 12'h0, 12'h0}};
        tbl[3] = '{10'h3FC, 4'b1000, 1'b1, 2, '{12'h3FF, 12'h401, 12'h0, 12'h0, 12'h0}};
        tbl[4] = '{10'h200, 4'b0110, 1'b0, 2, '{12'h201, 12'h202, 12'h0, 12'h0, 12'h0}};
        tbl[5] = '{10'h154, 4'b0000, 1'b1, 1, '{12'h402, 12'h0, 12'h0, 12'h0, 12'h0}};

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", evt_stall, 0);
        chk("rst_req", aer_req, 0);
        chk("rst_addr", aer_addr, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_err", err_drop, 0);
        chk("rst_cnt", spike_cnt, 0);
        rst = 1'b0;
        tick();

        // Directed table: words in order, spikes ahead of their marker, 3-cycle REQ latency.
        ack_mode = 1;
        for (int i = 0; i < 6; i++) begin
            got.delete();
            pulse_vec(tbl[i].base, tbl[i].spikes, tbl[i].ts);
            if (tbl[i].spikes != 0) begin
                lat = 1;
                while (!aer_req && lat < 10) begin tick(); lat++; end
                chk($sformatf("tbl%0d_latency", i), lat, 3);
            end
            wait_idle($sformatf("tbl%0d", i), 100);
            chk($sformatf("tbl%0d_count", i), got.size(), tbl[i].n);
            for (int j = 0; j < tbl[i].n && j < got.size(); j++)
                chk($sformatf("tbl%0d_word%0d", i, j), got[j], tbl[i].w[j]);
        end

        // FIFO fill with ACK held low, then full in-order delivery.
        got.delete();
        ack_mode = 0;
        for (int v = 0; v < 5; v++) begin
            lat = 0;
            while (evt_stall && lat < 50) begin tick(); lat++; end
            chk($sformatf("fill_wait%0d", v), 32'(lat < 50), 1);
            pulse_vec(10'h100 + 10'(4 * v), 4'b1111, 1'b0);
        end
        repeat (10) tick();
        chk("fill_stall", evt_stall, 1);
        chk("fill_empty", fifo_empty, 0);
        chk("fill_req", aer_req, 1);
        chk("fill_err", err_drop, 0);
        ack_mode = 1;
        wait_idle("fill", 300);
        chk("fill_count", got.size(), 20);
        for (int j = 0; j < 20 && j < got.size(); j++)
            chk($sformatf("fill_word%0d", j), got[j], 12'h100 + 12'(j));

        // Vector arriving while stalled is dropped and flagged stickily.
        got.delete();
        ack_mode = 0;
        pulse_vec(10'h200, 4'b1111, 1'b0);
        pulse_vec(10'h300, 4'b0001, 1'b0);
        chk("drop_err", err_drop, 1);
        ack_mode = 1;
        wait_idle("drop", 100);
        chk("drop_count", got.size(), 4);
        for (int j = 0; j < 4 && j < got.size(); j++)
            chk($sformatf("drop_word%0d", j), got[j], 12'h200 + 12'(j));
        repeat (5) tick();
        chk("drop_sticky", err_drop, 1);

        // Step counter wrap and TREF restart.
        got.delete();
        pulse_tref();
        for (int k = 0; k < 9; k++) begin
            pulse_tstep();
            wait_idle("mark", 50);
        end
        chk("mark_count", got.size(), 9);
        for (int k = 0; k < 9 && k < got.size(); k++)
            chk($sformatf("mark_word%0d", k), got[k], 12'h400 + 12'(k % 8));
        got.delete();
        for (int k = 0; k < 3; k++) begin pulse_tstep(); wait_idle("mark2", 50); end
        pulse_tref();
        pulse_tstep();
        wait_idle("mark3", 50);
        chk("tref_count", got.size(), 4);
        if (got.size() == 4) begin
            chk("tref_w0", got[0], 12'h401);
            chk("tref_w2", got[2], 12'h403);
            chk("tref_w3", got[3], 12'h400);
        end

        // Asynchronous reset in the middle of a request.
        ack_mode = 0;
        pulse_vec(10'h040, 4'b0111, 1'b0);
        lat = 0;
        while (!aer_req && lat < 10) begin tick(); lat++; end
        chk("rst6_req_before", aer_req, 1);
        rst = 1'b1;
        #1;
        chk("rst6_req", aer_req, 0);
        chk("rst6_empty", fifo_empty, 1);
        chk("rst6_stall", evt_stall, 0);
        chk("rst6_err", err_drop, 0);
        chk("rst6_addr", aer_addr, 0);
        tick();
        rst = 1'b0;
        tick();

        // Spike-word counter: markers are not counted, TREF clears.
        got.delete();
        ack_mode = 1;
        pulse_tref();
        pulse_vec(10'h080, 4'b0111, 1'b1);
        wait_idle("cnt", 100);
        chk("cnt_words", got.size(), 4);
        chk("cnt_value", spike_cnt, CNT_EN ? 3 : 0);
        pulse_tref();
        chk("cnt_cleared", spike_cnt, 0);

        // Randomized traffic; the model comparison runs every cycle.
        ack_mode = 2;
        for (int c = 0; c < 3000; c++) begin
            evt_valid  = ($urandom_range(3, 0) == 0);
            evt_spikes = 4'($urandom);
            evt_base   = {8'($urandom), 2'b00};
            tstep      = ($urandom_range(15, 0) == 0);
            tref       = ($urandom_range(63, 0) == 0);
            tick();
        end
        evt_valid = 1'b0; tstep = 1'b0; tref = 1'b0;
        ack_mode = 1;
        wait_idle("rand", 500);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
